mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the memory arbiter.
//   owner_e          : which port owns the response slot in the next cycle
//   ADDR_W_DEF       : default word-address width
//   STARVE_LIMIT_DEF : default denied-fetch count before fetch wins
package core_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } owner_e;

  localparam int ADDR_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency memory between
// instruction fetch (if_*) and load/store (d_*).
//   clk, rst           : clock, async active-high reset
//   if_req/if_addr     : fetch request in; if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_be/d_addr/d_wdata : data request in; d_gnt, d_rvalid, d_rdata out
//   mem_en/we/be/addr/wdata : memory strobe and request out; mem_rdata in
// Data normally wins; a fetch denied STARVE_LIMIT cycles in a row wins
// the next cycle. Read data returns exactly one cycle after the grant.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  owner_e     owner_q, owner_d;
  logic       st_q;       // response in flight belongs to a store
  logic [3:0] starve_q;
  logic       force_if;

  // Byte-offset and high address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{if_addr, d_addr};

  assign force_if = (starve_q == 4'(STARVE_LIMIT));

  // Grants are held low during reset so nothing reaches memory.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || force_if)) if_gnt = 1'b1;
      else if (d_req)                     d_gnt  = 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_be   = 4'hF;
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'hF;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_wdata;
    end
  end

  // State register: owner, store flag, starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= IDLE;
      st_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      st_q     <= d_gnt & d_we;
      starve_q <= (if_req && !if_gnt) ? starve_q + 4'd1 : 4'd0;
    end
  end

  // Next owner follows this cycle's grant; no grant frees the slot.
  always_comb begin
    owner_d = IDLE;
    if (if_gnt)     owner_d = RESP_IF;
    else if (d_gnt) owner_d = RESP_D;
  end

  // Response outputs; a store acknowledges with zero data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'h0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'h0;
    case (owner_q)
      RESP_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_rdata  = st_q ? 32'h0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'h0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [31:0]   d_addr = 32'h0, d_wdata = 32'h0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: consecutive fetch denials, and what kind of response is owed
  // next cycle (0 none, 1 fetch, 2 load, 3 store).
  int denied = 0;
  int pend   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Sample at the falling edge, compare every output, then advance model.
  task automatic cyc();
    logic        eig, edg, fwin;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    @(negedge clk);
    eig = 1'b0; edg = 1'b0; ea = 32'h0; ew = 32'h0; eb = 4'h0; ewe = 1'b0;
    if (rst) pend = 0;
    if (!rst) begin
      fwin = if_req && (!d_req || denied == LIM);
      eig  = fwin;
      edg  = d_req && !fwin;
      if (eig) begin
        ea = 32'(if_addr[AW+1:2]); eb = 4'hF;
      end else if (edg) begin
        ea  = 32'(d_addr[AW+1:2]);
        ewe = d_we;
        eb  = d_we ? d_be : 4'hF;
        ew  = d_wdata;
      end
    end
    chk("if_gnt",    32'(if_gnt),    32'(eig));
    chk("d_gnt",     32'(d_gnt),     32'(edg));
    chk("mem_en",    32'(mem_en),    32'(eig | edg));
    chk("mem_we",    32'(mem_we),    32'(ewe));
    chk("mem_be",    32'(mem_be),    32'(eb));
    chk("mem_addr",  32'(mem_addr),  ea);
    chk("mem_wdata", mem_wdata,      ew);
    chk("if_rvalid", 32'(if_rvalid), 32'(pend == 1));
    chk("if_rdata",  if_rdata,       (pend == 1) ? mem_rdata : 32'h0);
    chk("d_rvalid",  32'(d_rvalid),  32'(pend >= 2));
    chk("d_rdata",   d_rdata,        (pend == 2) ? mem_rdata : 32'h0);
    if (rst) begin
      denied = 0;
      pend   = 0;
    end else begin
      denied = (if_req && !eig) ? denied + 1 : 0;
      pend   = eig ? 1 : (edg ? (d_we ? 3 : 2) : 0);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with requests asserted: nothing may be granted.
    cyc();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    adv();
    if_req = 1'b1; d_req = 1'b1;
    cyc();
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_d_gnt",  32'(d_gnt),  32'h0);
    adv();

    // Fetch in first cycle after release.
    rst = 1'b0; d_req = 1'b0;
    if_addr = 32'h0000_0010; mem_rdata = 32'h0000_0013;
    cyc();
    chk("fetch_gnt",  32'(if_gnt),   32'h1);
    chk("fetch_addr", 32'(mem_addr), 32'h0004);
    adv();
    if_req = 1'b0;
    cyc();
    chk("fetch_rvalid", 32'(if_rvalid), 32'h1);
    chk("fetch_rdata",  if_rdata,       32'h0000_0013);
    adv();

    // Store with partial byte enables.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
    d_addr = 32'h0000_0104; d_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("st_we",    32'(mem_we),   32'h1);
    chk("st_be",    32'(mem_be),   32'h3);
    chk("st_addr",  32'(mem_addr), 32'h0041);
    chk("st_wdata", mem_wdata,     32'hDEAD_BEEF);
    adv();
    d_req = 1'b0; mem_rdata = 32'h5555_5555;
    cyc();
    chk("st_rvalid", 32'(d_rvalid), 32'h1);
    chk("st_rdata",  d_rdata,       32'h0);
    adv();

    // Both held: four data grants, then forced fetch, repeating.
    d_we = 1'b0; d_addr = 32'h0000_0200; if_addr = 32'h0000_0300;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_rdata = 32'h1000 + 32'(i);
      cyc();
      chk("starve_if", 32'(if_gnt), 32'((i % 5) == 4));
      chk("starve_d",  32'(d_gnt),  32'((i % 5) != 4));
      adv();
    end

    // Alternating fetch / load back-to-back.
    for (int i = 0; i < 7; i++) begin
      if_req = (i < 6) && (i % 2 == 0);
      d_req  = (i < 6) && (i % 2 == 1);
      mem_rdata = 32'h0100 + 32'(i);
      cyc();
      chk("alt_never_both", 32'(if_rvalid & d_rvalid), 32'h0);
      if (i >= 1) chk("alt_port", 32'({if_rvalid, d_rvalid}), (i % 2 == 1) ? 32'h2 : 32'h1);
      adv();
    end

    // Store with no bytes enabled still completes.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_wdata = 32'h1234_5678;
    cyc();
    chk("be0_gnt", 32'(d_gnt),  32'h1);
    chk("be0_be",  32'(mem_be), 32'h0);
    chk("be0_we",  32'(mem_we), 32'h1);
    adv();
    d_req = 1'b0; d_we = 1'b0;
    cyc();
    chk("be0_ack", 32'(d_rvalid), 32'h1);
    adv();

    // Fetch drops after two denials; counter restarts from zero.
    if_req = 1'b1; d_req = 1'b1;
    cyc(); adv(); cyc(); adv();
    if_req = 1'b0;
    cyc(); adv();
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("drop_if", 32'(if_gnt), 32'(i == 4));
      adv();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc(); adv();

    // Reset in the cycle after a load grant discards the response.
    d_req = 1'b1; d_addr = 32'hABCD_0006;
    cyc();
    chk("wrap_daddr", 32'(mem_addr), 32'h4001);
    adv();
    d_req = 1'b0; rst = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    cyc();
    chk("rst_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_rdata",  d_rdata,       32'h0);
    adv();
    cyc(); adv();
    rst = 1'b0; d_req = 1'b1;
    cyc();
    chk("post_rst_gnt",    32'(d_gnt),    32'h1);
    chk("post_rst_rvalid", 32'(d_rvalid), 32'h0);
    adv();
    d_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    cyc();
    chk("post_rst_load", d_rdata, 32'h0BAD_F00D);
    adv();

    // Top-of-memory fetch address wraps to the last word.
    if_req = 1'b1; if_addr = 32'hFFFF_FFFC;
    cyc();
    chk("wrap_addr", 32'(mem_addr), 32'h0000_FFFF);
    adv();
    if_req = 1'b0; mem_rdata = 32'h0000_1234;
    cyc();
    chk("wrap_rvalid", 32'(if_rvalid), 32'h1);
    chk("wrap_rdata",  if_rdata,       32'h0000_1234);
    adv();
    cyc(); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
